cordic_vectoring: RTL

- Inverse of the rotation-mode `cordic` block: iterative vectoring-mode CORDIC.
- Takes a signed fixed-point vector (x_in, y_in) and returns its angle, atan2(y, x), in degrees, plus its gain-corrected magnitude.
- Same Q(wi.wf) format, EN/start control style and degree angle convention as `cordic`, so the two blocks chain for round-trip checking.
- One micro-rotation per enabled clock.

---
 rtl/cordic_pkg.sv | 49 ++++
 rtl/cordic_vec_stage.sv | 50 +++++
 rtl/cordic_vectoring.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared CORDIC constants, degree arctangent table and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    // Fractional bits of the tables below (Q16.16)
    localparam int          c_tab_frac = 16;
    localparam logic [31:0] c_inv_k    = 32'h0000_9B75;
    localparam int          c_iw       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ITER = 2'd2,
        ST_POST = 2'd3
    } state_t;

    // atan(2^-i) in degrees, Q16.16, rounded to nearest
    function automatic logic [31:0] atan_q16(input logic [c_iw-1:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:    v = 32'h002D_0000;
            5'd1:    v = 32'h001A_90A7;
            5'd2:    v = 32'h000E_0947;
            5'd3:    v = 32'h0007_2001;
            5'd4:    v = 32'h0003_938B;
            5'd5:    v = 32'h0001_CA38;
            5'd6:    v = 32'h0000_E52A;
            5'd7:    v = 32'h0000_7297;
            5'd8:    v = 32'h0000_394C;
            5'd9:    v = 32'h0000_1CA6;
            5'd10:   v = 32'h0000_0E53;
            5'd11:   v = 32'h0000_0729;
            5'd12:   v = 32'h0000_0395;
            5'd13:   v = 32'h0000_01CA;
            5'd14:   v = 32'h0000_00E5;
            5'd15:   v = 32'h0000_0073;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_vec_stage.sv
// ============================================================================
// Module   : cordic_vec_stage
// Brief    : One combinational vectoring-mode micro-rotation (drives y toward 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int XW = 34,
    parameter int ZW = 32,
    parameter int FW = 16
) (
    input  logic signed [XW-1:0]   x_cur,
    input  logic signed [XW-1:0]   y_cur,
    input  logic signed [ZW-1:0]   z_cur,
    input  logic        [c_iw-1:0] idx,
    output logic signed [XW-1:0]   x_nxt,
    output logic signed [XW-1:0]   y_nxt,
    output logic signed [ZW-1:0]   z_nxt
);

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic signed [ZW-1:0] w_atan;

    assign w_x_sh = x_cur >>> idx;
    assign w_y_sh = y_cur >>> idx;
    // Rescale the Q16.16 table entry to the angle port's fractional width
    assign w_atan = ZW'((((ZW+FW)'(atan_q16(idx))) << FW) >> c_tab_frac);

    always_comb begin
        x_nxt = x_cur;
        y_nxt = y_cur;
        z_nxt = z_cur;
        if (!y_cur[XW-1]) begin
            x_nxt = x_cur + w_y_sh;
            y_nxt = y_cur - w_x_sh;
            z_nxt = z_cur + w_atan;
        end else begin
            x_nxt = x_cur - w_y_sh;
            y_nxt = y_cur + w_x_sh;
            z_nxt = z_cur - w_atan;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_vectoring.sv
// ============================================================================
// Module   : cordic_vectoring
// Brief    : Iterative vectoring CORDIC: atan2(y,x) in degrees plus magnitude.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int wi = 16,
    parameter int wf = 16,
    parameter int N  = 16,
    parameter int GB = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic                    start,
    input  logic signed [wi+wf-1:0] x_in,
    input  logic signed [wi+wf-1:0] y_in,
    output logic signed [wi+wf-1:0] ang_out,
    output logic        [wi+wf-1:0] mag_out,
    output logic                    busy,
    output logic                    done
);

    localparam int W  = wi + wf;
    localparam int XW = W + GB;
    localparam int ZW = W;
    localparam int PW = XW + wf + 2;

    localparam logic signed [ZW-1:0] c_deg90   = ZW'(90) <<< wf;
    localparam logic signed [ZW-1:0] c_deg180  = ZW'(180) <<< wf;
    localparam logic signed [PW-1:0] c_inv_k_q = (PW'(c_inv_k) << wf) >> c_tab_frac;
    localparam logic signed [PW-1:0] c_half    = PW'(1) <<< (wf - 1);
    localparam logic        [W-1:0]  c_w_max   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] c_mag_max = PW'(c_w_max);

    state_t               r_state;
    logic    [c_iw-1:0]   r_cnt;
    // GB extra integer bits absorb the ~2.33x growth of a full-scale vector
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic signed [ZW-1:0] r_z;
    logic                 r_zero;
    logic                 r_neg_axis;

    logic signed [XW-1:0] w_x_nxt;
    logic signed [XW-1:0] w_y_nxt;
    logic signed [ZW-1:0] w_z_nxt;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic        [W-1:0]  w_mag;

    cordic_vec_stage #(
        .XW (XW),
        .ZW (ZW),
        .FW (wf)
    ) u_stage (
        .x_cur (r_x),
        .y_cur (r_y),
        .z_cur (r_z),
        .idx   (r_cnt),
        .x_nxt (w_x_nxt),
        .y_nxt (w_y_nxt),
        .z_nxt (w_z_nxt)
    );

    assign w_prod   = PW'(r_x) * c_inv_k_q;
    assign w_scaled = (w_prod + c_half) >>> wf;

    always_comb begin
        w_mag = w_scaled[W-1:0];
        if (w_scaled < 0) begin
            w_mag = '0;
        end else if (w_scaled > c_mag_max) begin
            w_mag = c_w_max;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_zero     <= 1'b0;
            r_neg_axis <= 1'b0;
            ang_out    <= '0;
            mag_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x        <= XW'(x_in);
                        r_y        <= XW'(y_in);
                        r_z        <= '0;
                        r_cnt      <= '0;
                        r_zero     <= (x_in == '0) && (y_in == '0);
                        r_neg_axis <= x_in[W-1] && (y_in == '0);
                        busy       <= 1'b1;
                        r_state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (EN) begin
                        if (!r_x[XW-1]) begin
                            r_z <= '0;
                        end else if (!r_y[XW-1]) begin
                            r_x <= r_y;
                            r_y <= -r_x;
                            r_z <= c_deg90;
                        end else begin
                            r_x <= -r_y;
                            r_y <= r_x;
                            r_z <= -c_deg90;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (EN) begin
                        r_x <= w_x_nxt;
                        r_y <= w_y_nxt;
                        r_z <= w_z_nxt;
                        if (r_cnt == c_iw'(N - 1)) begin
                            r_state <= ST_POST;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (EN) begin
                        // Degenerate inputs get exact angles instead of the iteration residue
                        if (r_zero) begin
                            ang_out <= '0;
                        end else if (r_neg_axis) begin
                            ang_out <= c_deg180;
                        end else begin
                            ang_out <= r_z;
                        end
                        mag_out <= w_mag;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
